// File: rtl/branch_unit_ras_pkg.sv
// Shared definitions for the branch resolution unit: opcode encodings and
// flag-register bit positions (flags are packed {V,S,C,Z}).
package branch_unit_ras_pkg;

  typedef enum logic [6:0] {
    OP_B    = 7'b1000000,
    OP_BR   = 7'b1000001,
    OP_BZ   = 7'b1000010,
    OP_BNZ  = 7'b1000011,
    OP_BCY  = 7'b1000100,
    OP_BNCY = 7'b1000101,
    OP_BS   = 7'b1000110,
    OP_BNS  = 7'b1000111,
    OP_BV   = 7'b1001000,
    OP_BNV  = 7'b1001001,
    OP_CALL = 7'b1001010,
    OP_RET  = 7'b1001011
  } op_e;

  localparam int unsigned FZ = 0;
  localparam int unsigned FC = 1;
  localparam int unsigned FS = 2;
  localparam int unsigned FV = 3;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack.
//  push/pop      : one operation per cycle (mutually exclusive by opcode)
//  push_data     : address to push
//  top_data      : newest entry (entry at ptr-1), valid when !empty
//  empty         : no entries held
//  ovf / unf     : single-cycle strobes for push-when-full / pop-when-empty
// A push on a full stack overwrites the oldest entry (ptr wraps onto it) and
// count stays saturated; a pop on an empty stack leaves ptr/count untouched.
module branch_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     count;
  logic              full;

  assign full     = (count == CW'(RAS_DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[ptr - PW'(1)];
  assign ovf      = push && full;
  assign unf      = pop && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only readable once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch-resolution unit with flag register and return-address stack.
//  flag_we/flags_in      : flag register write ({V,S,C,Z}), forwarded to a
//                          request accepted in the same cycle
//  req_*                 : branch request (valid/ready), opcode, pc, offset,
//                          rs value, ra fallback for RAS underflow
//  resp_*                : registered result (valid/ready), taken, next PC
//  ras_ovf / ras_unf     : sticky RAS overflow / underflow, cleared by rst
module branch_unit_ras
  import branch_unit_ras_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OFF_W     = 25,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PC_INC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_op,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] ra_fallback,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic [ADDR_W-1:0] resp_target,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [3:0]        flags_q;
  logic [3:0]        flags_eff;
  logic              accept;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] tgt_d;
  logic [ADDR_W-1:0] ras_top;
  logic              taken_d;
  logic              cond_flag;
  logic              push;
  logic              pop;
  logic              ras_empty;
  logic              ovf_stb;
  logic              unf_stb;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign flags_eff = flag_we ? flags_in : flags_q;
  assign nxt       = req_pc + ADDR_W'(PC_INC);
  assign rel       = nxt + {{(ADDR_W-OFF_W){req_off[OFF_W-1]}}, req_off};

  // Conditional opcodes come in pairs: bits [3:1] pick the flag, bit 0 negates.
  always_comb begin
    cond_flag = 1'b0;
    case (req_op[3:1])
      3'b001:  cond_flag = flags_eff[FZ];
      3'b010:  cond_flag = flags_eff[FC];
      3'b011:  cond_flag = flags_eff[FS];
      3'b100:  cond_flag = flags_eff[FV];
      default: cond_flag = 1'b0;
    endcase
  end

  always_comb begin
    taken_d = 1'b0;
    tgt_d   = nxt;
    push    = 1'b0;
    pop     = 1'b0;
    case (req_op)
      OP_B: begin
        taken_d = 1'b1;
        tgt_d   = rel;
      end
      OP_BR: begin
        taken_d = 1'b1;
        tgt_d   = nxt + req_rs;
      end
      OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BS, OP_BNS, OP_BV, OP_BNV: begin
        taken_d = cond_flag ^ req_op[0];
        if (taken_d) tgt_d = rel;
      end
      OP_CALL: begin
        taken_d = 1'b1;
        tgt_d   = rel;
        push    = accept;
      end
      OP_RET: begin
        taken_d = 1'b1;
        pop     = accept;
        tgt_d   = ras_empty ? ra_fallback : ras_top;
      end
      default: ;
    endcase
  end

  branch_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (nxt),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .ovf       (ovf_stb),
    .unf       (unf_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      resp_valid  <= 1'b0;
      resp_taken  <= 1'b0;
      resp_target <= '0;
      ras_ovf     <= 1'b0;
      ras_unf     <= 1'b0;
    end else begin
      if (flag_we) flags_q <= flags_in;
      if (accept) begin
        resp_valid  <= 1'b1;
        resp_taken  <= taken_d;
        resp_target <= tgt_d;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (ovf_stb) ras_ovf <= 1'b1;
      if (unf_stb) ras_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_unit_ras.sv
module tb_branch_unit_ras;

  localparam int ADDR_W    = 32;
  localparam int OFF_W     = 25;
  localparam int RAS_DEPTH = 8;
  localparam int PC_INC    = 1;

  logic              clk;
  logic              rst;
  logic              flag_we;
  logic [3:0]        flags_in;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_op;
  logic [ADDR_W-1:0] req_pc;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_rs;
  logic [ADDR_W-1:0] ra_fallback;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_taken;
  logic [ADDR_W-1:0] resp_target;
  logic              ras_ovf;
  logic              ras_unf;

  int n_vec = 0;
  int n_err = 0;

  branch_unit_ras #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .RAS_DEPTH (RAS_DEPTH),
    .PC_INC    (PC_INC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flag_we     (flag_we),
    .flags_in    (flags_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_pc      (req_pc),
    .req_off     (req_off),
    .req_rs      (req_rs),
    .ra_fallback (ra_fallback),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_taken  (resp_taken),
    .resp_target (resp_target),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flags as a nibble, RAS as a bounded LIFO queue.
  logic [3:0]  m_flags;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf, m_valid, m_taken;
  logic [31:0] m_target;

  function automatic void model_clear();
    m_flags  = 4'h0;
    m_ras.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_valid  = 1'b0;
    m_taken  = 1'b0;
    m_target = 32'h0;
  endfunction

  function automatic void model_accept(input logic [6:0] op, input logic [31:0] pc,
                                       input logic [24:0] off, input logic [31:0] rs,
                                       input logic [31:0] fb, input logic [3:0] f);
    logic [31:0] nxt, rel;
    int   off_i;
    bit   is_cond, cond;
    nxt   = pc + PC_INC;
    off_i = off[24] ? int'(off) - (1 << 25) : int'(off);
    rel   = nxt + 32'(off_i);
    is_cond  = 1'b0;
    cond     = 1'b0;
    m_valid  = 1'b1;
    m_taken  = 1'b0;
    m_target = nxt;
    case (op)
      7'h40: begin m_taken = 1'b1; m_target = rel; end
      7'h41: begin m_taken = 1'b1; m_target = nxt + rs; end
      7'h42: begin is_cond = 1'b1; cond = (f[0] == 1'b1); end
      7'h43: begin is_cond = 1'b1; cond = (f[0] == 1'b0); end
      7'h44: begin is_cond = 1'b1; cond = (f[1] == 1'b1); end
      7'h45: begin is_cond = 1'b1; cond = (f[1] == 1'b0); end
      7'h46: begin is_cond = 1'b1; cond = (f[2] == 1'b1); end
      7'h47: begin is_cond = 1'b1; cond = (f[2] == 1'b0); end
      7'h48: begin is_cond = 1'b1; cond = (f[3] == 1'b1); end
      7'h49: begin is_cond = 1'b1; cond = (f[3] == 1'b0); end
      7'h4A: begin
        m_taken  = 1'b1;
        m_target = rel;
        m_ras.push_back(nxt);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      7'h4B: begin
        m_taken = 1'b1;
        if (m_ras.size() == 0) begin
          m_target = fb;
          m_unf    = 1'b1;
        end else begin
          m_target = m_ras.pop_back();
        end
      end
      default: ;
    endcase
    if (is_cond && cond) begin
      m_taken  = 1'b1;
      m_target = rel;
    end
  endfunction

  // Drive one request that is accepted at the next edge; leaves time at edge+1.
  task automatic send(input logic [6:0] op, input logic [31:0] pc, input logic [24:0] off,
                      input logic [31:0] rs, input logic [31:0] fb,
                      input logic fwe, input logic [3:0] fin);
    req_op = op; req_pc = pc; req_off = off; req_rs = rs; ra_fallback = fb;
    flag_we = fwe; flags_in = fin; req_valid = 1'b1;
    model_accept(op, pc, off, rs, fb, fwe ? fin : m_flags);
    if (fwe) m_flags = fin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flag_we   = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1; flags_in = f; req_valid = 1'b0;
    m_flags = f;
    @(posedge clk); #1;
    flag_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    resp_ready = 1'b1;
    set_flags(4'b0001);
    send(7'h4B, 32'h0, 25'h0, 32'h0, 32'h77, 1'b0, 4'h0);   // underflow -> unf set
    n_vec++;
    if (ras_unf !== 1'b1) begin n_err++; $display("FAIL reset_pre_unf got=%b exp=1", ras_unf); end
    resp_ready = 1'b0;
    send(7'h4A, 32'h700, 25'h0, 32'h0, 32'h0, 1'b0, 4'h0);  // call in flight
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if ({resp_valid, resp_taken, ras_ovf, ras_unf} !== 4'b0000 || resp_target !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b t=%b tgt=%h ovf=%b unf=%b exp all 0",
               resp_valid, resp_taken, resp_target, ras_ovf, ras_unf);
    end
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    send(7'h42, 32'h100, 25'h10, 32'h0, 32'h0, 1'b0, 4'h0);  // flags cleared -> bz not taken
    n_vec++;
    if (resp_taken !== 1'b0 || resp_target !== 32'h101) begin
      n_err++; $display("FAIL reset_flags got t=%b tgt=%h exp t=0 tgt=101", resp_taken, resp_target);
    end
    send(7'h4B, 32'h0, 25'h0, 32'h0, 32'h99, 1'b0, 4'h0);   // RAS emptied -> fallback
    n_vec++;
    if (resp_target !== 32'h99 || ras_unf !== 1'b1) begin
      n_err++; $display("FAIL reset_ras_empty got tgt=%h unf=%b exp tgt=99 unf=1", resp_target, ras_unf);
    end
  endtask

  task automatic test_cond();
    do_reset();
    set_flags(4'b0001);
    send(7'h42, 32'h100, 25'h10, 32'h0, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b1 || resp_target !== 32'h111) begin
      n_err++; $display("FAIL cond_bz got t=%b tgt=%h exp t=1 tgt=111", resp_taken, resp_target);
    end
    send(7'h43, 32'h100, 25'h10, 32'h0, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b0 || resp_target !== 32'h101) begin
      n_err++; $display("FAIL cond_bnz got t=%b tgt=%h exp t=0 tgt=101", resp_taken, resp_target);
    end
    send(7'h42, 32'h100, 25'h10, 32'h0, 32'h0, 1'b1, 4'b0000);
    n_vec++;
    if (resp_taken !== 1'b0 || resp_target !== 32'h101) begin
      n_err++; $display("FAIL cond_forward got t=%b tgt=%h exp t=0 tgt=101", resp_taken, resp_target);
    end
    for (int unsigned k = 0; k < 8; k++) begin
      logic [3:0] f;
      logic [6:0] op;
      f  = 4'($urandom);
      op = 7'(7'h42 + k);
      send(op, 32'h300, 25'h4, 32'h0, 32'h0, 1'b1, f);
      n_vec++;
      if (resp_taken !== m_taken || resp_target !== m_target) begin
        n_err++;
        $display("FAIL cond_op%h got t=%b tgt=%h exp t=%b tgt=%h", op, resp_taken, resp_target, m_taken, m_target);
      end
    end
  endtask

  task automatic test_neg_off();
    send(7'h40, 32'h200, 25'h1FFFFF0, 32'h0, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b1 || resp_target !== 32'h1F1) begin
      n_err++; $display("FAIL neg_off got t=%b tgt=%h exp t=1 tgt=1f1", resp_taken, resp_target);
    end
    send(7'h41, 32'h10, 25'h0, 32'h40, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b1 || resp_target !== 32'h51) begin
      n_err++; $display("FAIL br_rs got t=%b tgt=%h exp t=1 tgt=51", resp_taken, resp_target);
    end
    send(7'h3F, 32'h80, 25'h5, 32'h0, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b0 || resp_target !== 32'h81) begin
      n_err++; $display("FAIL bad_op got t=%b tgt=%h exp t=0 tgt=81", resp_taken, resp_target);
    end
  endtask

  task automatic test_ras();
    logic [31:0] exp_t [3];
    exp_t[0] = 32'h31; exp_t[1] = 32'h21; exp_t[2] = 32'h11;
    do_reset();
    send(7'h4A, 32'h10, 25'h100, 32'h0, 32'h0, 1'b0, 4'h0);
    n_vec++;
    if (resp_taken !== 1'b1 || resp_target !== 32'h111) begin
      n_err++; $display("FAIL call_target got t=%b tgt=%h exp t=1 tgt=111", resp_taken, resp_target);
    end
    send(7'h4A, 32'h20, 25'h100, 32'h0, 32'h0, 1'b0, 4'h0);
    send(7'h4A, 32'h30, 25'h100, 32'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      send(7'h4B, 32'h900, 25'h0, 32'h0, 32'hABC, 1'b0, 4'h0);
      n_vec++;
      if (resp_taken !== 1'b1 || resp_target !== exp_t[i]) begin
        n_err++; $display("FAIL ret%0d got t=%b tgt=%h exp t=1 tgt=%h", i, resp_taken, resp_target, exp_t[i]);
      end
    end
    n_vec++;
    if (ras_unf !== 1'b0) begin n_err++; $display("FAIL ras_unf_early got=%b exp=0", ras_unf); end
    send(7'h4B, 32'h900, 25'h0, 32'h0, 32'hABC, 1'b0, 4'h0);
    n_vec++;
    if (resp_target !== 32'hABC || ras_unf !== 1'b1) begin
      n_err++; $display("FAIL ras_underflow got tgt=%h unf=%b exp tgt=abc unf=1", resp_target, ras_unf);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      send(7'h4A, 32'(32'h1000 + i * 16), 25'h8, 32'h0, 32'h0, 1'b0, 4'h0);
      if (i == RAS_DEPTH - 1) begin
        n_vec++;
        if (ras_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got=%b exp=0", ras_ovf); end
      end
    end
    n_vec++;
    if (ras_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", ras_ovf); end
    for (int i = RAS_DEPTH; i >= 1; i--) begin
      logic [31:0] exp;
      exp = 32'(32'h1000 + i * 16 + 1);
      send(7'h4B, 32'h0, 25'h0, 32'h0, 32'hDEAD, 1'b0, 4'h0);
      n_vec++;
      if (resp_target !== exp) begin
        n_err++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, resp_target, exp);
      end
    end
    send(7'h4B, 32'h0, 25'h0, 32'h0, 32'hDEAD, 1'b0, 4'h0);
    n_vec++;
    if (resp_target !== 32'hDEAD || ras_unf !== 1'b1) begin
      n_err++; $display("FAIL ovf_drained got tgt=%h unf=%b exp tgt=dead unf=1", resp_target, ras_unf);
    end
  endtask

  task automatic test_stall();
    do_reset();
    resp_ready = 1'b0;
    send(7'h4A, 32'h500, 25'h20, 32'h0, 32'h0, 1'b0, 4'h0);
    req_op = 7'h4A; req_pc = 32'h600; req_off = 25'h40; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready c%0d got=%b exp=0", c, req_ready); end
      n_vec++;
      if (resp_valid !== 1'b1 || resp_taken !== 1'b1 || resp_target !== 32'h521) begin
        n_err++;
        $display("FAIL stall_hold c%0d got v=%b t=%b tgt=%h exp v=1 t=1 tgt=521", c, resp_valid, resp_taken, resp_target);
      end
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (resp_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got=%b exp=0", resp_valid); end
    send(7'h4B, 32'h0, 25'h0, 32'h0, 32'hF00, 1'b0, 4'h0);
    n_vec++;
    if (resp_target !== 32'h501) begin n_err++; $display("FAIL stall_ret got=%h exp=501", resp_target); end
    send(7'h4B, 32'h0, 25'h0, 32'h0, 32'hF00, 1'b0, 4'h0);
    n_vec++;
    if (resp_target !== 32'hF00) begin n_err++; $display("FAIL stall_nopush got=%h exp=f00", resp_target); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic exp_ready, acc;
      logic [6:0] op;
      op          = 7'($urandom_range(32'h3F, 32'h4C));
      if ($urandom_range(0, 3) == 0) op = 7'($urandom_range(32'h4A, 32'h4B));
      req_op      = op;
      req_pc      = $urandom;
      req_off     = ($urandom_range(0, 1) == 0) ? 25'($urandom) : 25'($signed($urandom_range(0, 64)) - 32);
      req_rs      = $urandom;
      ra_fallback = $urandom;
      flag_we     = ($urandom_range(0, 3) == 0);
      flags_in    = 4'($urandom);
      req_valid   = ($urandom_range(0, 3) != 0);
      resp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !m_valid || resp_ready;
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      acc = req_valid && exp_ready;
      if (acc) model_accept(op, req_pc, req_off, req_rs, ra_fallback, flag_we ? flags_in : m_flags);
      else if (resp_ready) m_valid = 1'b0;
      if (flag_we) m_flags = flags_in;
      @(posedge clk); #1;
      n_vec++;
      if (resp_valid !== m_valid || resp_taken !== m_taken || resp_target !== m_target ||
          ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        n_err++;
        $display("FAIL rnd_resp c%0d got v=%b t=%b tgt=%h ovf=%b unf=%b exp v=%b t=%b tgt=%h ovf=%b unf=%b",
                 c, resp_valid, resp_taken, resp_target, ras_ovf, ras_unf,
                 m_valid, m_taken, m_target, m_ovf, m_unf);
      end
    end
    req_valid = 1'b0;
    flag_we   = 1'b0;
    resp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; flags_in = 4'h0; req_valid = 1'b0; req_op = 7'h0;
    req_pc = '0; req_off = '0; req_rs = '0; ra_fallback = '0; resp_ready = 1'b1;
    model_clear();
    #12;
    test_reset();
    test_cond();
    test_neg_off();
    test_ras();
    test_overflow();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
